mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access pipeline stage. Consumes the execute stage's result bundle: ALU result, Rt store data, destination register, and the RegWrite/MemRead/MemtoReg/MemWrite controls.
- Drives a req/ack data-memory port with byte, half and word loads and stores; load data is aligned and sign- or zero-extended.
- Stalls upstream stages while a memory transaction is outstanding.
- Registers the write-back bundle for the WB stage.

Parameters:
- TIMEOUT, 255, BUSY cycles without MemAck before the transaction is abandoned (1..2^TO_W-1).
- TO_W, 8, width of the timeout counter.

Ports:
- Clock      in   1   single clock, rising edge
- Reset      in   1   synchronous, active-high
- ALUIn      in   32  ALU result from execute; the memory address for accesses
- RtDataIn   in   32  store data from execute
- RAddrIn    in   5   destination register
- RegWriteIn, MemReadIn, MemtoRegIn, MemWriteIn  in  1 each  controls from execute
- MemSize    in   2   access size (mem_size_t)
- MemSigned  in   1   1 = sign-extend loads
- MemAddr    out  32  word-aligned address ({ALUIn[31:2],2'b00})
- MemWData   out  32  lane-replicated store data
- MemBE      out  4   byte enables
- MemReq     out  1   request valid
- MemWe      out  1   1 = write
- MemRData   in   32  read data, valid with MemAck
- MemAck     in   1   transaction complete
- Stall      out  1   freeze upstream stages (combinational)
- WBData     out  32  registered write-back data
- WBAddr     out  5   registered destination register
- WBRegWrite out  1   registered write enable
- AddrErr    out  1   one-cycle pulse: misaligned access
- BusErr     out  1   one-cycle pulse: timeout

Behaviour:
- Reset:
  - State IDLE, counter 0, holding registers 0.
  - All registered outputs 0: MemReq, MemWe, MemBE, MemAddr, MemWData, WB*, AddrErr, BusErr.
  - Reset mid-transaction drops MemReq at the next edge; a late MemAck is ignored.
- Access means MemReadIn|MemWriteIn. Misalignment is defined as:
  - WORD: ALUIn[1:0]!=0
  - HALF: ALUIn[0]!=0
  - BYTE: never misaligned
- IDLE, no access:
  - WB registers load the bundle at the next edge (1-cycle latency).
  - WBData = ALUIn, WBAddr = RAddrIn, WBRegWrite = RegWriteIn.
  - Stall = 0.
- IDLE, misaligned access:
  - No request is issued.
  - AddrErr is registered high for 1 cycle.
  - WB gets a bubble (WBRegWrite = 0). Stall = 0.
- IDLE, aligned access:
  - Stall = 1 this cycle.
  - Address, size, signed flag, RAddr, MemtoReg and RegWrite are latched.
  - MemReq/MemWe/MemBE/MemWData/MemAddr are registered high/valid at the edge; next state BUSY.
  - WB gets a bubble.
- BUSY:
  - Request outputs are held stable until ack.
  - Stall = !MemAck.
  - WB gets a bubble each cycle without ack.
  - Counter increments each BUSY cycle.
- BUSY with MemAck:
  - MemReq drops at the edge; state goes to IDLE; counter clears.
  - Load: WBData = aligned/extended MemRData.
  - Store: WBData = latched ALU value, WBRegWrite = latched RegWrite.
- BUSY with counter==TIMEOUT-1 and no ack:
  - MemReq drops; BusErr pulses for 1 cycle.
  - WB gets a bubble; Stall = 0 in that cycle; state goes to IDLE.
- Minimum access occupancy: 1 stall cycle plus the ack cycle. WB update happens at the ack edge.
- MemAck is ignored while MemReq = 0. MemAck and timeout in the same cycle: ack wins.
- Store lanes (little-endian, a = ALUIn[1:0]):
  - BYTE: BE = 1<<a, WData = {4{Rt[7:0]}}
  - HALF: BE = a[1] ? 4'b1100 : 4'b0011, WData = {2{Rt[15:0]}}
  - WORD: BE = 4'b1111, WData = Rt
- Load extraction: MemRData >> (8*a), truncated to size, then sign-extended if MemSigned, else zero-extended. For loads, MemBE is the size mask and MemWe = 0.
- MemReadIn and MemWriteIn both set: treated as a write.

Decomposition:
- Package mem_pkg:
  - mem_size_t enum: BYTE=2'd0, HALF=2'd1, WORD=2'd2
  - mem_state_t enum: IDLE, BUSY
  - Byte-enable constants
- Sub-module mem_load_align: combinational extraction and extension, ports (RData, Offset[1:0], Size, Signed) -> Data[31:0]. The store-lane logic stays inline.

Test Plan:
- Non-memory op: ALUIn=32'h1234, RAddrIn=5, RegWriteIn=1 -> next cycle WBData=32'h1234, WBAddr=5, WBRegWrite=1; Stall never asserted.
- Signed byte load: ALUIn=32'h103, MemSize=BYTE, MemSigned=1, MemRData=32'h80xxxxxx, ack 3 cycles after MemReq -> MemAddr=32'h100, MemBE=4'b1000, Stall high until the ack cycle, WBData=32'hFFFFFF80.
- Unsigned half load: ALUIn=32'h102, MemRData=32'hBEEF0000 -> WBData=32'h0000BEEF.
- Byte store: ALUIn=32'h201, Rt=32'hAB, MemWriteIn=1 -> MemWe=1, MemBE=4'b0010, MemWData=32'hABABABAB; WBRegWrite=0.
- Misaligned word load: ALUIn=32'h102 -> MemReq stays 0, AddrErr 1-cycle pulse, WBRegWrite=0, Stall=0.
- Timeout with TIMEOUT=4 and no ack -> MemReq high exactly 4 cycles, BusErr pulse, Stall released.
- Reset asserted during BUSY, followed by a late ack -> outputs 0, no WB write.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access stage: access sizes,
// FSM states, byte-enable masks and alignment rules.
package mem_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_t;

  localparam logic [3:0] BE_BYTE    = 4'b0001;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

  // The unused size encoding behaves like WORD everywhere in this stage.
  function automatic logic isMisaligned(input mem_size_t size, input logic [1:0] offset);
    case (size)
      BYTE:    return 1'b0;
      HALF:    return offset[0];
      default: return (offset != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] laneMask(input mem_size_t size, input logic [1:0] offset);
    case (size)
      BYTE:    return BE_BYTE << offset;
      HALF:    return offset[1] ? BE_HALF_HI : BE_HALF_LO;
      default: return BE_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load-data extraction: shifts the addressed lane down, truncates to the
// access size, then sign- or zero-extends to 32 bits.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0] RData,
  input  logic [1:0]  Offset,
  input  mem_size_t   Size,
  input  logic        Signed,
  output logic [31:0] Data
);

  logic [31:0] shifted;

  always_comb begin
    shifted = RData >> {Offset, 3'b000};
    case (Size)
      BYTE:    Data = {{24{Signed & shifted[7]}}, shifted[7:0]};
      HALF:    Data = {{16{Signed & shifted[15]}}, shifted[15:0]};
      default: Data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: drives a req/ack data port, stalls upstream
// while a transaction is outstanding, and registers the write-back bundle.
module mem_stage
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TO_W    = 8
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] ALUIn,
  input  logic [31:0] RtDataIn,
  input  logic [4:0]  RAddrIn,
  input  logic        RegWriteIn,
  input  logic        MemReadIn,
  input  logic        MemtoRegIn,
  input  logic        MemWriteIn,
  input  mem_size_t   MemSize,
  input  logic        MemSigned,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [3:0]  MemBE,
  output logic        MemReq,
  output logic        MemWe,
  input  logic [31:0] MemRData,
  input  logic        MemAck,
  output logic        Stall,
  output logic [31:0] WBData,
  output logic [4:0]  WBAddr,
  output logic        WBRegWrite,
  output logic        AddrErr,
  output logic        BusErr
);

  localparam logic [TO_W-1:0] CntLast = TO_W'(TIMEOUT - 1);

  mem_state_t      state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  mem_size_t   size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  offset_q, offset_d;
  logic [4:0]  raddr_q, raddr_d;
  logic        memtoReg_q, memtoReg_d;
  logic        regWrite_q, regWrite_d;
  logic        isWrite_q, isWrite_d;
  logic [31:0] aluVal_q, aluVal_d;

  logic        memReq_q, memReq_d;
  logic        memWe_q, memWe_d;
  logic [3:0]  memBE_q, memBE_d;
  logic [31:0] memAddr_q, memAddr_d;
  logic [31:0] memWData_q, memWData_d;

  logic [31:0] wbData_q, wbData_d;
  logic [4:0]  wbAddr_q, wbAddr_d;
  logic        wbRegWrite_q, wbRegWrite_d;
  logic        addrErr_q, addrErr_d;
  logic        busErr_q, busErr_d;

  logic        access;
  logic        timeoutHit;
  logic [31:0] storeData;
  logic [31:0] loadData;

  assign access     = MemReadIn | MemWriteIn;
  assign timeoutHit = (cnt_q == CntLast);

  mem_load_align u_load_align (
    .RData  (MemRData),
    .Offset (offset_q),
    .Size   (size_q),
    .Signed (signed_q),
    .Data   (loadData)
  );

  always_comb begin
    case (MemSize)
      BYTE:    storeData = {4{RtDataIn[7:0]}};
      HALF:    storeData = {2{RtDataIn[15:0]}};
      default: storeData = RtDataIn;
    endcase
  end

  // Request outputs and write-back default to holding; WB write enable and
  // error pulses default low so every non-updating cycle is a bubble.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    signed_d     = signed_q;
    offset_d     = offset_q;
    raddr_d      = raddr_q;
    memtoReg_d   = memtoReg_q;
    regWrite_d   = regWrite_q;
    isWrite_d    = isWrite_q;
    aluVal_d     = aluVal_q;
    memReq_d     = memReq_q;
    memWe_d      = memWe_q;
    memBE_d      = memBE_q;
    memAddr_d    = memAddr_q;
    memWData_d   = memWData_q;
    wbData_d     = wbData_q;
    wbAddr_d     = wbAddr_q;
    wbRegWrite_d = 1'b0;
    addrErr_d    = 1'b0;
    busErr_d     = 1'b0;
    Stall        = 1'b0;

    case (state_q)
      IDLE: begin
        if (!access) begin
          wbData_d     = ALUIn;
          wbAddr_d     = RAddrIn;
          wbRegWrite_d = RegWriteIn;
        end else if (isMisaligned(MemSize, ALUIn[1:0])) begin
          addrErr_d = 1'b1;
        end else begin
          Stall      = 1'b1;
          size_d     = MemSize;
          signed_d   = MemSigned;
          offset_d   = ALUIn[1:0];
          raddr_d    = RAddrIn;
          memtoReg_d = MemtoRegIn;
          regWrite_d = RegWriteIn;
          isWrite_d  = MemWriteIn;
          aluVal_d   = ALUIn;
          memReq_d   = 1'b1;
          memWe_d    = MemWriteIn;
          memBE_d    = laneMask(MemSize, ALUIn[1:0]);
          memAddr_d  = {ALUIn[31:2], 2'b00};
          memWData_d = storeData;
          cnt_d      = '0;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        // An ack arriving on the final counted cycle still completes normally.
        if (MemAck) begin
          memReq_d     = 1'b0;
          memWe_d      = 1'b0;
          cnt_d        = '0;
          state_d      = IDLE;
          wbAddr_d     = raddr_q;
          wbRegWrite_d = regWrite_q;
          wbData_d     = (!isWrite_q && memtoReg_q) ? loadData : aluVal_q;
        end else if (timeoutHit) begin
          memReq_d = 1'b0;
          memWe_d  = 1'b0;
          busErr_d = 1'b1;
          cnt_d    = '0;
          state_d  = IDLE;
        end else begin
          Stall = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      size_q       <= BYTE;
      signed_q     <= 1'b0;
      offset_q     <= 2'b00;
      raddr_q      <= '0;
      memtoReg_q   <= 1'b0;
      regWrite_q   <= 1'b0;
      isWrite_q    <= 1'b0;
      aluVal_q     <= '0;
      memReq_q     <= 1'b0;
      memWe_q      <= 1'b0;
      memBE_q      <= '0;
      memAddr_q    <= '0;
      memWData_q   <= '0;
      wbData_q     <= '0;
      wbAddr_q     <= '0;
      wbRegWrite_q <= 1'b0;
      addrErr_q    <= 1'b0;
      busErr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      offset_q     <= offset_d;
      raddr_q      <= raddr_d;
      memtoReg_q   <= memtoReg_d;
      regWrite_q   <= regWrite_d;
      isWrite_q    <= isWrite_d;
      aluVal_q     <= aluVal_d;
      memReq_q     <= memReq_d;
      memWe_q      <= memWe_d;
      memBE_q      <= memBE_d;
      memAddr_q    <= memAddr_d;
      memWData_q   <= memWData_d;
      wbData_q     <= wbData_d;
      wbAddr_q     <= wbAddr_d;
      wbRegWrite_q <= wbRegWrite_d;
      addrErr_q    <= addrErr_d;
      busErr_q     <= busErr_d;
    end
  end

  assign MemReq     = memReq_q;
  assign MemWe      = memWe_q;
  assign MemBE      = memBE_q;
  assign MemAddr    = memAddr_q;
  assign MemWData   = memWData_q;
  assign WBData     = wbData_q;
  assign WBAddr     = wbAddr_q;
  assign WBRegWrite = wbRegWrite_q;
  assign AddrErr    = addrErr_q;
  assign BusErr     = busErr_q;

endmodule
